pulse_delay_shaper: RTL and testbench
=====================================

# pulse_delay_shaper

Multi-channel programmable pulse delay and shaping unit. Each channel watches an active-low trigger input, waits a programmable number of clock cycles, then drives an active-low output pulse of programmable width. It replaces fixed-timing single-channel delay blocks wherever control strobes (e.g. write/chip-select phases toward the display/RTC interface) must be retimed. It adds per-build channel count, runtime delay and width, edge/level trigger modes, retrigger mode, and busy/done status.

## Interface
- CHANNELS, 2: number of independent channels (1–8).
- CNT_W, 4: width of the delay and width counters; maximum delay 2^CNT_W−1, maximum width 2^CNT_W−1.

- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  global run enable; when low, every channel freezes.
- level_i  in  1  0 = falling-edge trigger, 1 = level trigger (trigger while low, sampled in IDLE).
- retrig_i  in  1  1 = a trigger while busy restarts the channel.
- delay_i  in  CNT_W  delay D in cycles, shared by all channels, captured per channel at trigger.
- width_i  in  CNT_W  pulse width W in cycles, captured per channel at trigger; 0 is treated as 1.
- trig_n_i  in  CHANNELS  active-low triggers, synchronous to clk_i.
- pulse_n_o  out  CHANNELS  active-low shaped pulses, registered.
- busy_o  out  CHANNELS  high while the channel is in DELAY or PULSE.
- done_o  out  CHANNELS  one-cycle high strobe when a pulse completes.

## Operation
- Per-channel state: IDLE, DELAY, PULSE; one down-counter cnt (CNT_W bits); captured width register wreg; trigger history register prev.
- prev <= trig_n_i[c] on every clock, including when enable_i=0; reset value 1.
- Trigger event: edge mode: prev=1 and trig_n_i=0. Level mode: trig_n_i=0.
- All transitions below require enable_i=1. When enable_i=0, state, cnt, wreg and pulse_n_o hold. Triggers are ignored and done_o=0.
- IDLE: on a trigger event, go to DELAY, set cnt<=delay_i, wreg<=max(width_i,1).
- DELAY: if cnt=0, go to PULSE, set pulse_n_o<=0, cnt<=wreg−1. Otherwise cnt<=cnt−1.
- PULSE: if cnt=0, go to IDLE, set pulse_n_o<=1, done_o<=1 for one cycle. Otherwise cnt<=cnt−1.
- Trigger event in DELAY or PULSE:
  - retrig_i=1: go to DELAY, set cnt<=delay_i, wreg<=max(width_i,1), pulse_n_o<=1, no done_o. This takes priority over the normal transition on the same edge.
  - retrig_i=0: ignored. This includes an event on the same edge as PULSE exit.
- Level mode with trig_n held low re-arms from IDLE on the cycle after done_o. The result is a periodic train of period D+W+2.
- Channels are fully independent; no arbitration between them.
- busy_o is combinational from state (state≠IDLE).

## Timing
- Reset values: pulse_n_o all 1, busy_o all 0, done_o all 0. All states IDLE, cnt 0, wreg 1, prev all 1.
- Reset asserted mid-pulse forces pulse_n_o high immediately (asynchronously), with no done_o.
- Trigger sampled at edge k:
  - busy_o high after edge k.
  - pulse_n_o low after edge k+1+D.
  - pulse_n_o high again after edge k+1+D+W, so the pulse is low for exactly W cycles.
  - done_o high for the single cycle after edge k+1+D+W.
- D=0: pulse_n_o low after edge k+1. Minimum trigger-to-pulse latency is 1 cycle.
- Counter arithmetic is unsigned CNT_W-bit. Wrap-around never occurs because decrement happens only when cnt≠0.
- An enable_i low gap of N cycles stretches the current phase by exactly N cycles.
- delay_i and width_i changes while a channel is busy do not affect that channel until its next trigger.

## Test plan
- Basic (CNT_W=4, edge mode): ch0 falls at edge 10 with D=3, W=7 -> busy_o[0]=1 after edge 10; pulse_n_o[0]=0 after edges 14..20; high after edge 21; done_o[0]=1 for one cycle after edge 21; ch1 stays idle.
- Zero values: D=0, W=0 -> pulse_n_o low for exactly 1 cycle, after edge k+1.
- Retrigger: D=3, W=7, second falling edge at k+6 (during PULSE):
  - retrig_i=1 -> pulse_n_o returns high after k+6, low again after k+10, no done_o at k+6.
  - retrig_i=0 -> second edge ignored; pulse ends after k+11.
- Level mode: trig_n_i[1] held low with D=2, W=3 -> repeated pulses of period 7 cycles. Edge mode with the same stimulus -> exactly one pulse.
- Enable freeze: deassert enable_i for 5 cycles mid-DELAY -> pulse_n_o low edge shifts by exactly 5 cycles; trigger edges during the gap produce no pulse.
- Async reset during PULSE (both channels active) -> pulse_n_o=2'b11 and busy_o=0 before the next clock edge; first post-reset falling edge behaves as in the basic case.

Source files
------------

// File: rtl/pulse_delay_shaper.sv
// -----------------------------------------------------------------------------
// pulse_delay_shaper
//   Multi-channel programmable pulse delay and shaping unit. Each channel
//   watches an active-low trigger, waits delay_i cycles, then drives an
//   active-low pulse of width_i cycles (a width of 0 behaves as 1).
//
// Parameters
//   CHANNELS  number of independent channels (1..8)
//   CNT_W     width of the delay / width counters
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   enable_i   global run enable; low freezes every channel
//   level_i    0 = falling-edge trigger, 1 = level (low) trigger
//   retrig_i   1 = a trigger while busy restarts the channel
//   delay_i    delay in cycles, captured per channel at trigger
//   width_i    pulse width in cycles, captured per channel at trigger
//   trig_n_i   active-low triggers, one per channel
//   pulse_n_o  active-low shaped pulses, registered
//   busy_o     high while a channel is delaying or pulsing
//   done_o     one-cycle strobe when a pulse completes
// -----------------------------------------------------------------------------
module pulse_delay_shaper #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                level_i,
   input  logic                retrig_i,
   input  logic [CNT_W-1:0]    delay_i,
   input  logic [CNT_W-1:0]    width_i,
   input  logic [CHANNELS-1:0] trig_n_i,
   output logic [CHANNELS-1:0] pulse_n_o,
   output logic [CHANNELS-1:0] busy_o,
   output logic [CHANNELS-1:0] done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // A zero width still produces a one-cycle pulse.
   function automatic logic [CNT_W-1:0] width_floor(input logic [CNT_W-1:0] w);
      return (w == '0) ? ONE : w;
   endfunction

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           state, state_nxt;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic [CNT_W-1:0] wreg, wreg_nxt;
      logic             prev;
      logic             pulse_n, pulse_n_nxt;
      logic             done, done_nxt;
      logic             trig;

      // Edge mode needs the previous sample high; level mode only needs low.
      assign trig = ~trig_n_i[c] & (level_i | prev);

      always_comb begin
         state_nxt   = state;
         cnt_nxt     = cnt;
         wreg_nxt    = wreg;
         pulse_n_nxt = pulse_n;
         done_nxt    = 1'b0;
         if (enable_i) begin
            case (state)
               IDLE: begin
                  if (trig) begin
                     state_nxt = DELAY;
                     cnt_nxt   = delay_i;
                     wreg_nxt  = width_floor(width_i);
                  end
               end
               DELAY, PULSE: begin
                  // A restart wins over the phase transition on the same edge.
                  if (trig && retrig_i) begin
                     state_nxt   = DELAY;
                     cnt_nxt     = delay_i;
                     wreg_nxt    = width_floor(width_i);
                     pulse_n_nxt = 1'b1;
                  end else if (cnt != '0) begin
                     cnt_nxt = cnt - ONE;
                  end else if (state == DELAY) begin
                     state_nxt   = PULSE;
                     pulse_n_nxt = 1'b0;
                     cnt_nxt     = wreg - ONE;
                  end else begin
                     state_nxt   = IDLE;
                     pulse_n_nxt = 1'b1;
                     done_nxt    = 1'b1;
                  end
               end
               default: begin
                  state_nxt   = IDLE;
                  pulse_n_nxt = 1'b1;
               end
            endcase
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            wreg    <= ONE;
            prev    <= 1'b1;
            pulse_n <= 1'b1;
            done    <= 1'b0;
         end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wreg    <= wreg_nxt;
            prev    <= trig_n_i[c];
            pulse_n <= pulse_n_nxt;
            done    <= done_nxt;
         end
      end

      assign pulse_n_o[c] = pulse_n;
      assign busy_o[c]    = (state != IDLE);
      assign done_o[c]    = done;
   end

endmodule

// File: tb/tb_pulse_delay_shaper.sv
// -----------------------------------------------------------------------------
// tb_pulse_delay_shaper
//   Self-checking bench for pulse_delay_shaper. A reference model tracks, per
//   channel, how many enabled cycles have elapsed since the last accepted
//   trigger and derives pulse/busy/done from that elapsed count.
// -----------------------------------------------------------------------------
module tb_pulse_delay_shaper;
   localparam int CH = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          level;
   logic          retrig;
   logic [CW-1:0] delay;
   logic [CW-1:0] width;
   logic [CH-1:0] trig_n;
   logic [CH-1:0] pulse_n;
   logic [CH-1:0] busy;
   logic [CH-1:0] done;

   int total = 0;
   int bad   = 0;

   pulse_delay_shaper #(.CHANNELS(CH), .CNT_W(CW)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (en),
      .level_i  (level),
      .retrig_i (retrig),
      .delay_i  (delay),
      .width_i  (width),
      .trig_n_i (trig_n),
      .pulse_n_o(pulse_n),
      .busy_o   (busy),
      .done_o   (done)
   );

   always #5 clk = ~clk;

   // reference model state
   bit m_act  [CH];
   int m_el   [CH];
   int m_d    [CH];
   int m_w    [CH];
   bit m_prev [CH];
   bit m_done [CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_act[c] = 0; m_el[c] = 0; m_d[c] = 0; m_w[c] = 1;
         m_prev[c] = 1; m_done[c] = 0;
      end
   endtask

   // One rising edge of the model, using the inputs as they stand at the edge.
   task automatic model_step();
      bit ev;
      for (int c = 0; c < CH; c++) begin
         ev = !trig_n[c] && (level || m_prev[c]);
         m_done[c] = 0;
         if (en) begin
            if (!m_act[c]) begin
               if (ev) begin
                  m_act[c] = 1; m_el[c] = 0;
                  m_d[c] = int'(delay); m_w[c] = (width == 0) ? 1 : int'(width);
               end
            end else if (ev && retrig) begin
               m_el[c] = 0;
               m_d[c] = int'(delay); m_w[c] = (width == 0) ? 1 : int'(width);
            end else begin
               m_el[c]++;
               if (m_el[c] == m_d[c] + m_w[c] + 1) begin
                  m_act[c] = 0; m_done[c] = 1;
               end
            end
         end
         m_prev[c] = trig_n[c];
      end
   endtask

   task automatic compare_model();
      logic [CH-1:0] ep, eb, ed;
      for (int c = 0; c < CH; c++) begin
         ep[c] = !(m_act[c] && m_el[c] >= m_d[c] + 1 && m_el[c] <= m_d[c] + m_w[c]);
         eb[c] = m_act[c];
         ed[c] = m_done[c];
      end
      check("pulse_n", 32'(pulse_n), 32'(ep));
      check("busy",    32'(busy),    32'(eb));
      check("done",    32'(done),    32'(ed));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
      @(negedge clk);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, "_pulse_n"}, 32'(pulse_n), {32{1'b1}} >> (32 - CH));
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic basic_case(input string tag);
      int lows, first, dn, b1;
      level = 0; retrig = 0; delay = 4'd3; width = 4'd7;
      trig_n[0] = 1'b0;
      tick();
      check({tag, "_busy0"}, 32'(busy[0]), 32'd1);
      lows = 0; first = -1; dn = 0; b1 = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 2) trig_n[0] = 1'b1;
         tick();
         if (!pulse_n[0]) begin lows++; if (first < 0) first = i; end
         if (done[0]) dn++;
         if (busy[1]) b1++;
         if (i == 11) check({tag, "_done_at_end"}, 32'(done[0]), 32'd1);
      end
      check({tag, "_low_cycles"}, 32'(lows),  32'd7);
      check({tag, "_first_low"},  32'(first), 32'd4);
      check({tag, "_done_count"}, 32'(dn),    32'd1);
      check({tag, "_ch1_idle"},   32'(b1),    32'd0);
   endtask

   task automatic retrig_case(input bit r);
      int lows, first2, dn;
      level = 0; retrig = r; delay = 4'd3; width = 4'd7;
      trig_n[0] = 1'b0;
      tick();
      lows = 0; first2 = -1; dn = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 2) trig_n[0] = 1'b1;
         if (i == 6) trig_n[0] = 1'b0;
         if (i == 8) trig_n[0] = 1'b1;
         tick();
         if (!pulse_n[0]) lows++;
         if (!pulse_n[0] && i > 6 && first2 < 0) first2 = i;
         if (done[0]) dn++;
         if (r && i == 6) begin
            check("retrig_high_at_k6", 32'(pulse_n[0]), 32'd1);
            check("retrig_no_done_k6", 32'(done[0]),    32'd0);
         end
         if (!r && i == 11) begin
            check("noretrig_end_k11",  32'(pulse_n[0]), 32'd1);
            check("noretrig_done_k11", 32'(done[0]),    32'd1);
         end
      end
      if (r) begin
         check("retrig_relow_k10", 32'(first2), 32'd10);
         check("retrig_lows",      32'(lows),   32'd9);
      end else begin
         check("noretrig_lows",    32'(lows),   32'd7);
      end
      check(r ? "retrig_done_cnt" : "noretrig_done_cnt", 32'(dn), 32'd1);
   endtask

   task automatic level_case(input bit lv);
      int falls;
      logic last;
      level = lv; retrig = 0; delay = 4'd2; width = 4'd3;
      trig_n[1] = 1'b0;
      falls = 0; last = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         tick();
         if (last && !pulse_n[1]) falls++;
         last = pulse_n[1];
      end
      check(lv ? "level_pulses" : "edge_pulses", 32'(falls), lv ? 32'd3 : 32'd1);
      trig_n[1] = 1'b1;
      level = 0;
      idle_ticks(12);
   endtask

   task automatic freeze_case();
      int first, b1;
      level = 0; retrig = 0; delay = 4'd6; width = 4'd2;
      trig_n[0] = 1'b0;
      tick();
      first = -1; b1 = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 1) trig_n[0] = 1'b1;
         if (i == 3) en = 1'b0;
         if (i == 3) trig_n[0] = 1'b0;
         if (i == 4) trig_n[1] = 1'b0;
         if (i == 5) trig_n[0] = 1'b1;
         if (i == 6) trig_n[1] = 1'b1;
         if (i == 8) en = 1'b1;
         tick();
         if (!pulse_n[0] && first < 0) first = i;
         if (busy[1]) b1++;
      end
      check("freeze_first_low", 32'(first), 32'd12);
      check("freeze_ch1_idle",  32'(b1),    32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; level = 1'b0; retrig = 1'b0;
      delay = '0; width = '0; trig_n = '1;
      model_reset();
      #1;
      check("reset_pulse_n", 32'(pulse_n), 32'h3);
      check("reset_busy",    32'(busy),    32'h0);
      check("reset_done",    32'(done),    32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      idle_ticks(9);

      basic_case("basic");
      idle_ticks(3);

      // zero delay and width
      begin
         int lows, first;
         delay = 4'd0; width = 4'd0; trig_n[1] = 1'b0;
         tick();
         trig_n[1] = 1'b1;
         lows = 0; first = -1;
         for (int i = 1; i <= 5; i++) begin
            tick();
            if (!pulse_n[1]) begin lows++; if (first < 0) first = i; end
         end
         check("zero_lows",  32'(lows),  32'd1);
         check("zero_first", 32'(first), 32'd1);
      end

      retrig_case(1'b1); idle_ticks(3);
      retrig_case(1'b0); idle_ticks(3);
      level_case(1'b1);
      level_case(1'b0);
      freeze_case();     idle_ticks(4);

      // reset while both channels are pulsing
      delay = 4'd1; width = 4'd10; trig_n = 2'b00;
      idle_ticks(4);
      trig_n = 2'b11;
      check("pre_reset_pulsing", 32'(pulse_n), 32'h0);
      async_reset("midpulse_reset");
      idle_ticks(2);
      basic_case("post_reset");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(3) == 0) trig_n[c] = ~trig_n[c];
         en    = ($urandom_range(7) != 0);
         if ($urandom_range(63) == 0) level  = ~level;
         if ($urandom_range(31) == 0) retrig = ~retrig;
         delay = CW'($urandom);
         width = CW'($urandom);
         if (i == 1500) async_reset("rand_reset");
         else tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
